// File: rtl/data_ram_pkg.sv
// Shared types for the data_ram block: access sizes, FSM states and the
// response pipeline stage record.
package data_ram_pkg;

  localparam int unsigned MAX_LATENCY = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        err;
  } resp_stage_t;

  // Byte-lane write mask for an access of the given size at byte offset off.
  function automatic logic [3:0] lane_mask(input size_t size, input logic [1:0] off);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << off;
      SZ_HALF: lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/data_ram_load_fmt.sv
// Load formatter: selects the addressed byte/half of a word, right-aligns it
// and applies sign or zero extension.
module data_ram_load_fmt
  import data_ram_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  size_t       size,
  input  logic        is_unsigned,
  output logic [31:0] rdata
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    sel_b = 8'(word >> {off, 3'b000});
    sel_h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: rdata = is_unsigned ? {24'h0, sel_b} : {{24{sel_b[7]}}, sel_b};
      SZ_HALF: rdata = is_unsigned ? {16'h0, sel_h} : {{16{sel_h[15]}}, sel_h};
      default: rdata = word;
    endcase
  end

endmodule

// File: rtl/data_ram.sv
// Byte/half/word data RAM with valid/ready requests, fixed-latency responses
// and sequential clear after reset. Define DATA_RAM_MISALIGN_TRAP_EN to trap misaligned accesses.
module data_ram
  import data_ram_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_t           state;
  logic [IDX_W-1:0] clr_idx;
  logic [31:0]      mem [DEPTH];
  resp_stage_t      pipe [LATENCY];
  resp_stage_t      stage_in;

  logic             accept;
  logic [IDX_W-1:0] idx;
  size_t            eff_size;
  logic [1:0]       off;
  logic             misaligned;
  logic [3:0]       be;
  logic [31:0]      wlanes;
  logic [31:0]      ld_word;
  logic [31:0]      ld_data;
  logic             unused_addr_bits;

  assign req_ready        = (state == ST_RUN);
  assign accept           = req_valid && req_ready;
  assign idx              = req_addr[2 +: IDX_W];
  assign unused_addr_bits = ^{req_addr[ADDR_W-1:IDX_W+2]};

  always_comb begin
    eff_size   = size_t'(req_size);
    off        = req_addr[1:0];
    misaligned = 1'b0;
`ifdef DATA_RAM_MISALIGN_TRAP_EN
    case (eff_size)
      SZ_HALF: misaligned = off[0];
      SZ_WORD: misaligned = (off != 2'b00);
      SZ_RSVD: misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
`else
    // Reserved size behaves as word; low address bits are forced aligned.
    if (eff_size == SZ_RSVD) eff_size = SZ_WORD;
    if (eff_size == SZ_HALF) off[0] = 1'b0;
    if (eff_size == SZ_WORD) off = 2'b00;
`endif
  end

  always_comb begin
    be = lane_mask(eff_size, off);
    case (eff_size)
      SZ_BYTE: wlanes = {4{req_wdata[7:0]}};
      SZ_HALF: wlanes = {2{req_wdata[15:0]}};
      default: wlanes = req_wdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
    end else if (state == ST_CLEAR) begin
      clr_idx <= clr_idx + 1'b1;
      if (clr_idx == IDX_W'(DEPTH - 1)) state <= ST_RUN;
    end
  end

  // The array has no reset; the CLEAR state zeroes it one word per cycle.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (accept && req_we && !misaligned) begin
      for (int unsigned l = 0; l < 4; l++) begin
        if (be[l]) mem[idx][8*l +: 8] <= wlanes[8*l +: 8];
      end
    end
  end

  assign ld_word = mem[idx];

  data_ram_load_fmt u_load_fmt (
    .word        (ld_word),
    .off         (off),
    .size        (eff_size),
    .is_unsigned (req_unsigned),
    .rdata       (ld_data)
  );

  always_comb begin
    stage_in = '0;
    if (accept) begin
      stage_in.valid = 1'b1;
      stage_in.err   = misaligned;
      if (!req_we && !misaligned) stage_in.rdata = ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= stage_in;
      for (int unsigned i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign resp_valid = pipe[LATENCY-1].valid;
  assign resp_rdata = pipe[LATENCY-1].rdata;
  assign resp_err   = pipe[LATENCY-1].err;

endmodule
